// File: rtl/eth_mac_tx_if.sv
// Byte-stream handshake between the header/payload generators and the MAC framer.
//   in_data  : frame byte (DA first, no preamble/FCS)
//   in_valid : in_data valid
//   in_last  : final frame byte, qualified by in_valid
//   in_ready : framer accepts in_data this cycle
// master = byte source, slave = framer.
interface eth_mac_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/eth_mac_tx.sv
// MAC transmit framer: wraps an incoming byte stream with preamble/SFD, pads short frames
// with zeros, appends the CRC-32 FCS (LS byte first) and enforces an inter-frame gap.
// Ports:
//   clk, rst      : byte clock, asynchronous active-high reset
//   in_if (slave) : in_data/in_valid/in_last/in_ready byte stream
//   tx_data/valid : GMII-style byte stream to rgmii_tx
//   busy          : framer not idle
//   frame_done    : pulse while the last FCS byte is on tx_data
//   err_underrun  : pulse when the source stalls mid-frame (frame abandoned)
//   err_oversize  : pulse when the frame grows past MAX_FRAME bytes
//   frame_count   : frames completed with FCS, wrapping
module eth_mac_tx #(
  parameter int unsigned MIN_FRAME = 60,
  parameter int unsigned MAX_FRAME = 1514,
  parameter int unsigned PREAMBLE  = 7,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic               clk,
  input  logic               rst,
  eth_mac_tx_if.slave        in_if,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               busy,
  output logic               frame_done,
  output logic               err_underrun,
  output logic               err_oversize,
  output logic [15:0]        frame_count
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StSfd  = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StPad  = 3'd4;
  localparam logic [2:0] StFcs  = 3'd5;
  localparam logic [2:0] StIfg  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;            // preamble index, FCS byte index or IFG count
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        err_underrun_q, err_underrun_d;
  logic        err_oversize_q, err_oversize_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic [16:0] byte_cnt_inc;
  logic [15:0] byte_cnt_sat;
  logic [31:0] fcs_word;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign byte_cnt_inc = {1'b0, byte_cnt_q} + 17'd1;
  assign byte_cnt_sat = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_inc[15:0];
  assign fcs_word     = ~crc_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    byte_cnt_d     = byte_cnt_q;
    crc_d          = crc_q;
    tx_data_d      = 8'h00;
    tx_valid_d     = 1'b0;
    in_ready_d     = 1'b0;
    frame_done_d   = 1'b0;
    err_underrun_d = 1'b0;
    err_oversize_d = 1'b0;
    frame_count_d  = frame_count_q;

    case (state_q)
      StIdle: begin
        crc_d      = 32'hFFFF_FFFF;
        byte_cnt_d = 16'h0;
        cnt_d      = 8'd0;
        // The waiting byte is not consumed here; it is taken once DATA raises in_ready.
        if (in_if.in_valid) begin
          state_d    = StPre;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h55;
          cnt_d      = 8'd1;
        end
      end
      StPre: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h55;
        if (cnt_q == 8'(PREAMBLE - 1)) state_d = StSfd;
        else                           cnt_d   = cnt_q + 8'd1;
      end
      StSfd: begin
        // Raise in_ready while SFD is on the wire so the first frame byte follows directly.
        tx_valid_d = 1'b1;
        tx_data_d  = 8'hD5;
        in_ready_d = 1'b1;
        state_d    = StData;
      end
      StData: begin
        if (in_if.in_valid) begin
          tx_valid_d     = 1'b1;
          tx_data_d      = in_if.in_data;
          crc_d          = crc_byte(crc_q, in_if.in_data);
          byte_cnt_d     = byte_cnt_sat;
          err_oversize_d = (byte_cnt_q == 16'(MAX_FRAME));
          if (in_if.in_last) begin
            cnt_d   = 8'd0;
            state_d = (byte_cnt_inc < 17'(MIN_FRAME)) ? StPad : StFcs;
          end else begin
            in_ready_d = 1'b1;
          end
        end else begin
          // Frame abandoned: no FCS, the IFG cycle already counts as idle.
          err_underrun_d = 1'b1;
          state_d        = StIfg;
          cnt_d          = 8'd1;
        end
      end
      StPad: begin
        tx_valid_d = 1'b1;
        crc_d      = crc_byte(crc_q, 8'h00);
        byte_cnt_d = byte_cnt_sat;
        if (byte_cnt_inc >= 17'(MIN_FRAME)) begin
          state_d = StFcs;
          cnt_d   = 8'd0;
        end
      end
      StFcs: begin
        tx_valid_d = 1'b1;
        tx_data_d  = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d      = cnt_q + 8'd1;
        if (cnt_q[1:0] == 2'd3) begin
          // First IFG cycle still shows the last FCS byte, hence the count starts at 0.
          state_d       = StIfg;
          cnt_d         = 8'd0;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      StIfg: begin
        if (cnt_q == 8'(IFG_BYTES)) state_d = StIdle;
        else                        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= 8'd0;
      byte_cnt_q     <= 16'h0;
      crc_q          <= 32'hFFFF_FFFF;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      err_underrun_q <= 1'b0;
      err_oversize_q <= 1'b0;
      frame_count_q  <= 16'h0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      crc_q          <= crc_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      err_underrun_q <= err_underrun_d;
      err_oversize_q <= err_oversize_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign err_underrun   = err_underrun_q;
  assign err_oversize   = err_oversize_q;
  assign frame_count    = frame_count_q;

endmodule
